// File: rtl/pm_pkg.sv
// Shared definitions for the power-monitor sweep sequencer.
//   - pm_state_t : sequencer FSM states
//   - MUX_W      : width of the analog mux select
//   - is_stuck() : true when a conversion result is all-zeros or all-ones
package pm_pkg;

  localparam int MUX_W        = 3;
  localparam int MAX_SAMPLE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CONVERT,
    S_STORE,
    S_DONE,
    S_WAIT
  } pm_state_t;

  // Mask covering the low w bits of a MAX_SAMPLE_W-wide value.
  function automatic logic [MAX_SAMPLE_W-1:0] width_mask(input int w);
    logic [MAX_SAMPLE_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_SAMPLE_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // A channel whose result is pinned to either rail is treated as stuck.
  function automatic logic is_stuck(input logic [MAX_SAMPLE_W-1:0] v, input int w);
    logic [MAX_SAMPLE_W-1:0] m;
    m = width_mask(w);
    return ((v & m) == '0) || ((v & m) == m);
  endfunction

endpackage

// File: rtl/pm_serial_rx.sv
// Serial conversion receiver for the power monitor.
// Generates cs_n/sclk for one SAMPLE_BITS-wide conversion and shifts `data`
// in MSB first on each sclk rising edge.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start          - one-cycle request to begin a conversion
//   abort          - drop any conversion in progress immediately
//   data           - serial input from the monitor
//   cs_n, sclk     - registered chip select (active-low) and serial clock
//   done           - high on the last cycle of a conversion
//   sample         - shift register contents (valid from the cycle after done)
module pm_serial_rx #(
  parameter int SAMPLE_BITS = 12,
  parameter int CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   data,
  output logic                   cs_n,
  output logic                   sclk,
  output logic                   done,
  output logic [SAMPLE_BITS-1:0] sample
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * SAMPLE_BITS);

  logic                   active;
  logic [DW-1:0]          div_cnt;
  logic [HW-1:0]          half_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic                   half_end;
  logic                   rise;

  assign half_end = (div_cnt == DW'(CLK_DIV - 1));
  // The conversion ends with the falling edge that closes the last high half.
  assign done     = active && half_end && (half_cnt == HW'(2 * SAMPLE_BITS - 1));
  assign rise     = active && half_end && !sclk;
  assign sample   = shreg;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      active   <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cs_n     <= 1'b0;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (done) begin
          active   <= 1'b0;
          cs_n     <= 1'b1;
          sclk     <= 1'b0;
          half_cnt <= '0;
        end else begin
          sclk     <= ~sclk;
          half_cnt <= half_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Data is captured on the clk cycle that drives sclk high.
  always_ff @(posedge clk) begin
    if (rise) shreg <= (shreg << 1) | SAMPLE_BITS'(data);
  end

endmodule

// File: rtl/power_monitor_sequencer.sv
// Autonomous sweep controller for the power-management serial monitor.
// Steps the analog mux over NUM_CH channels, waits SETTLE_CYCLES, runs one
// serial conversion per channel, stores results and flags stuck channels.
// A new sweep starts every PERIOD_CYCLES while enable is high.
// Optional build macro: KILL_SW_DEBOUNCE_EN - kill_sw is synchronised and
// must hold a new level for 65536 cycles before kill_active follows it;
// otherwise kill_active is kill_sw registered once.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   enable                  - run periodic sweeps
//   kill_sw / kill_active   - raw kill switch / registered kill state
//   data, mux, cs_n, sclk   - monitor interface
//   rd_ch, rd_data          - result read port (0 for rd_ch >= NUM_CH)
//   fault_clr, fault_flags  - clear pulse, sticky per-channel stuck flags
//   fault                   - OR of fault_flags
//   busy, sweep_done        - activity level, end-of-sweep pulse
module power_monitor_sequencer
  import pm_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SAMPLE_BITS   = 12,
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 50,
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   kill_sw,
  input  logic                   data,
  output logic [MUX_W-1:0]       mux,
  output logic                   cs_n,
  output logic                   sclk,
  input  logic [MUX_W-1:0]       rd_ch,
  output logic [SAMPLE_BITS-1:0] rd_data,
  input  logic                   fault_clr,
  output logic [NUM_CH-1:0]      fault_flags,
  output logic                   fault,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   kill_active
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam logic [MUX_W-1:0] LAST_CH = MUX_W'(NUM_CH - 1);

  pm_state_t              state;
  logic [MUX_W-1:0]       ch;
  logic [SW-1:0]          settle_cnt;
  logic [PW-1:0]          period_cnt;
  logic                   settle_end;
  logic                   period_end;
  logic                   rx_start;
  logic                   rx_done;
  logic [SAMPLE_BITS-1:0] rx_sample;
  logic                   store_en;
  logic                   stuck;
  logic [NUM_CH-1:0]      set_mask;
  logic [SAMPLE_BITS-1:0] regfile [2**MUX_W];

  // Kill switch conditioning
`ifdef KILL_SW_DEBOUNCE_EN
  logic        kill_s1;
  logic        kill_s2;
  logic [15:0] stab_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_s1     <= 1'b0;
      kill_s2     <= 1'b0;
      stab_cnt    <= '0;
      kill_active <= 1'b0;
    end else begin
      kill_s1 <= kill_sw;
      kill_s2 <= kill_s1;
      if (kill_s2 != kill_active) begin
        // 65536th consecutive differing cycle commits the new level.
        if (stab_cnt == 16'hFFFF) begin
          kill_active <= kill_s2;
          stab_cnt    <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) kill_active <= 1'b0;
    else       kill_active <= kill_sw;
  end
`endif

  assign settle_end = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign period_end = (period_cnt == PW'(PERIOD_CYCLES - 1));
  assign rx_start   = (state == S_SELECT) && settle_end && !kill_active;

  pm_serial_rx #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .CLK_DIV     (CLK_DIV)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .start  (rx_start),
    .abort  (kill_active),
    .data   (data),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .done   (rx_done),
    .sample (rx_sample)
  );

  // Sequencer FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ch         <= '0;
      mux        <= '0;
      settle_cnt <= '0;
      period_cnt <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      // Saturating period counter; an overrun sweep leaves WAIT at once.
      if (!period_end) period_cnt <= period_cnt + 1'b1;
      if (kill_active) begin
        state      <= S_IDLE;
        ch         <= '0;
        mux        <= '0;
        settle_cnt <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable) begin
              state      <= S_SELECT;
              ch         <= '0;
              mux        <= '0;
              settle_cnt <= '0;
              period_cnt <= '0;
              busy       <= 1'b1;
            end
          end
          S_SELECT: begin
            if (settle_end) begin
              state      <= S_CONVERT;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_CONVERT: begin
            if (rx_done) state <= S_STORE;
          end
          S_STORE: begin
            if (ch == LAST_CH) begin
              state      <= S_DONE;
              sweep_done <= 1'b1;
            end else if (!enable) begin
              state <= S_IDLE;
              ch    <= '0;
              mux   <= '0;
              busy  <= 1'b0;
            end else begin
              state <= S_SELECT;
              ch    <= ch + 1'b1;
              mux   <= ch + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_WAIT;
            busy  <= 1'b0;
          end
          S_WAIT: begin
            if (period_end) begin
              if (enable) begin
                state      <= S_SELECT;
                ch         <= '0;
                mux        <= '0;
                settle_cnt <= '0;
                period_cnt <= '0;
                busy       <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Result store and fault detection
  assign store_en = (state == S_STORE) && !kill_active;
  assign stuck    = is_stuck(MAX_SAMPLE_W'(rx_sample), SAMPLE_BITS);

  always_comb begin
    set_mask = '0;
    if (store_en && stuck) set_mask[ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**MUX_W; i++) regfile[i] <= '0;
      fault_flags <= '0;
    end else begin
      if (store_en) regfile[ch] <= rx_sample;
      // A flag being set in the same cycle as a clear survives.
      fault_flags <= (fault_clr ? '0 : fault_flags) | set_mask;
    end
  end

  assign fault = |fault_flags;

  always_comb begin
    rd_data = '0;
    if (int'(rd_ch) < NUM_CH) rd_data = regfile[rd_ch];
  end

endmodule

// File: tb/tb_power_monitor_sequencer.sv
// Directed self-checking bench for power_monitor_sequencer.
// dut   : SETTLE_CYCLES=4, CLK_DIV=2, PERIOD_CYCLES=2000
// dut_b : same but PERIOD_CYCLES=100 (sweep longer than the period)
module tb_power_monitor_sequencer;

  localparam int M_ANY_CONV = 0;
  localparam int M_CONV_CH  = 1;
  localparam int M_STORE    = 2;
  localparam int M_SD       = 3;
  localparam int M_SD_B     = 4;
  localparam int M_BUSY_CH  = 5;

  logic        clk = 1'b0;
  logic        reset, enable, kill_sw, fault_clr;
  logic        data = 1'b0;
  logic [2:0]  rd_ch;

  logic [2:0]  mux, mux_b;
  logic        cs_n, sclk, cs_n_b, sclk_b;
  logic [11:0] rd_data, rd_data_b;
  logic [7:0]  fault_flags, fault_flags_b;
  logic        fault, busy, sweep_done, kill_active;
  logic        fault_b, busy_b, sweep_done_b, kill_active_b;

  logic [11:0] ch_val [8];
  int          bit_idx = 0;
  logic        prev_sclk = 1'b0;
  int          cyc = 0;
  int          sd_cnt = 0;
  int          sd_last = 0;
  int          sd_prev = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  power_monitor_sequencer #(
    .SETTLE_CYCLES (4), .CLK_DIV (2), .PERIOD_CYCLES (2000)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .kill_sw (kill_sw), .data (data),
    .mux (mux), .cs_n (cs_n), .sclk (sclk), .rd_ch (rd_ch), .rd_data (rd_data),
    .fault_clr (fault_clr), .fault_flags (fault_flags), .fault (fault), .busy (busy),
    .sweep_done (sweep_done), .kill_active (kill_active)
  );

  power_monitor_sequencer #(
    .SETTLE_CYCLES (4), .CLK_DIV (2), .PERIOD_CYCLES (100)
  ) dut_b (
    .clk (clk), .reset (reset), .enable (enable), .kill_sw (kill_sw), .data (data),
    .mux (mux_b), .cs_n (cs_n_b), .sclk (sclk_b), .rd_ch (rd_ch), .rd_data (rd_data_b),
    .fault_clr (fault_clr), .fault_flags (fault_flags_b), .fault (fault_b), .busy (busy_b),
    .sweep_done (sweep_done_b), .kill_active (kill_active_b)
  );

  // Monitor model: presents bit (11 - n) of ch_val[mux] after n sclk rises.
  always @(negedge clk) begin
    cyc++;
    if (sweep_done) begin
      sd_prev = sd_last;
      sd_last = cyc;
      sd_cnt++;
    end
    if (cs_n) bit_idx = 0;
    else if (sclk && !prev_sclk) bit_idx++;
    prev_sclk = sclk;
    data = (bit_idx < 12) ? ch_val[mux][11 - bit_idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_for(input int mode, input logic [2:0] ch, input int lim, input string tag);
    bit   ok;
    logic pc;
    ok = 1'b0;
    pc = 1'b1;
    for (int i = 0; i < lim && !ok; i++) begin
      case (mode)
        M_ANY_CONV: ok = !cs_n;
        M_CONV_CH:  ok = !cs_n && (mux == ch);
        M_STORE:    ok = cs_n && !pc && (mux == ch);
        M_SD:       ok = sweep_done;
        M_SD_B:     ok = sweep_done_b;
        M_BUSY_CH:  ok = busy && (mux == ch);
        default:    ok = 1'b1;
      endcase
      pc = cs_n;
      if (!ok) tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int sd0;
    reset = 1'b1; enable = 1'b0; kill_sw = 1'b0; fault_clr = 1'b0; rd_ch = 3'd0;
    for (int k = 0; k < 8; k++) ch_val[k] = 12'h100 + 12'(k);
    tick(3);

    chk("rst_mux", 32'(mux), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sweep_done", 32'(sweep_done), 0);
    chk("rst_kill_active", 32'(kill_active), 0);
    chk("rst_fault_flags", 32'(fault_flags), 0);
    chk("rst_rd_data", 32'(rd_data), 0);

    reset = 1'b0;
    tick(2);
    chk("idle_no_enable", 32'(busy), 0);

    // Sweep 1: mux order and conversion length
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_for(M_ANY_CONV, 3'd0, 200, "conv_start_timeout");
      chk("conv_mux", 32'(mux), 32'(k));
      n = 0;
      while (!cs_n && n < 200) begin
        n++;
        tick();
      end
      chk("conv_len", 32'(n), 48);
    end
    wait_for(M_SD, 3'd0, 10, "sd1_timeout");

    // Short-period instance: DONE, WAIT, then straight back to SELECT.
    chk("b_sd_aligned", 32'(sweep_done_b), 1);
    tick();
    chk("b_wait_busy", 32'(busy_b), 0);
    chk("b_wait_sd", 32'(sweep_done_b), 0);
    tick();
    chk("b_select_busy", 32'(busy_b), 1);
    chk("b_select_mux", 32'(mux_b), 0);
    c0 = cyc;

    for (int k = 0; k < 8; k++) begin
      rd_ch = 3'(k);
      tick();
      chk("rd_sweep1", 32'(rd_data), 32'h100 + 32'(k));
    end
    chk("no_fault_flags", 32'(fault_flags), 0);
    chk("no_fault", 32'(fault), 0);

    wait_for(M_SD_B, 3'd0, 600, "b_sd_timeout");
    chk("b_back_to_back", 32'(cyc - c0), 424);

    wait_for(M_SD, 3'd0, 2100, "sd2_timeout");
    chk("sweep_period", 32'(sd_last - sd_prev), 2000);

    // Stuck channels
    ch_val[5] = 12'hFFF;
    ch_val[2] = 12'h000;
    tick();
    wait_for(M_SD, 3'd0, 2100, "sd3_timeout");
    chk("stuck_flags", 32'(fault_flags), 32'h24);
    chk("stuck_fault", 32'(fault), 1);

    // Register-write read timing and clear-vs-set priority
    ch_val[3] = 12'h0AB;
    rd_ch = 3'd3;
    wait_for(M_STORE, 3'd3, 2100, "store3_timeout");
    chk("rd_during_store_old", 32'(rd_data), 32'h103);
    tick();
    chk("rd_after_store_new", 32'(rd_data), 32'h0AB);
    wait_for(M_STORE, 3'd5, 400, "store5_timeout");
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_vs_set_flags", 32'(fault_flags), 32'h20);
    chk("clr_vs_set_fault", 32'(fault), 1);
    ch_val[2] = 12'h102;
    ch_val[5] = 12'h105;
    ch_val[6] = 12'h066;

`ifndef KILL_SW_DEBOUNCE_EN
    // Kill mid-conversion on channel 4
    ch_val[4] = 12'h444;
    wait_for(M_CONV_CH, 3'd4, 2100, "conv4_timeout");
    tick(10);
    kill_sw = 1'b1;
    tick(2);
    chk("kill_cs_n", 32'(cs_n), 1);
    chk("kill_sclk", 32'(sclk), 0);
    chk("kill_busy", 32'(busy), 0);
    chk("kill_mux", 32'(mux), 0);
    chk("kill_active_set", 32'(kill_active), 1);
    tick(5);
    chk("kill_hold_idle", 32'(busy), 0);
    rd_ch = 3'd4;
    tick();
    chk("kill_regfile_kept", 32'(rd_data), 32'h104);
    kill_sw = 1'b0;
    wait_for(M_BUSY_CH, 3'd0, 10, "restart_timeout");
    chk("restart_mux", 32'(mux), 0);
`endif

    // Enable dropped during SELECT of channel 6
    wait_for(M_BUSY_CH, 3'd6, 2100, "select6_timeout");
    enable = 1'b0;
    rd_ch = 3'd6;
    wait_for(M_STORE, 3'd6, 100, "store6_timeout");
    tick();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_mux", 32'(mux), 0);
    chk("drop_sweep_done", 32'(sweep_done), 0);
    chk("drop_ch6_stored", 32'(rd_data), 32'h066);
    sd0 = sd_cnt;
    tick(600);
    chk("drop_no_sweep_done", 32'(sd_cnt - sd0), 0);
    chk("drop_stays_idle", 32'(busy), 0);

`ifdef KILL_SW_DEBOUNCE_EN
    // Debounced kill switch
    kill_sw = 1'b1;
    tick(1000);
    chk("glitch_during", 32'(kill_active), 0);
    kill_sw = 1'b0;
    tick(5);
    chk("glitch_after", 32'(kill_active), 0);
    kill_sw = 1'b1;
    n = 0;
    while (!kill_active && n < 70000) begin
      tick();
      n++;
    end
    chk("debounce_latency", 32'(n), 65538);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
